// File: rtl/exhaustive_bist_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exhaustive_bist_ctrl                                                       |
// | Applies all 2^N_IN vectors to a small DUT, compacts responses in a MISR.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module exhaustive_bist_ctrl #(
    parameter int                N_IN  = 5,
    parameter int                N_OUT = 2,
    parameter int                SIG_W = 16,
    parameter logic [SIG_W-1:0]  POLY  = 16'h002D,
    parameter int                LAT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIG_W-1:0]  golden_sig,
    output logic [N_IN-1:0]   dut_in,
    input  logic [N_OUT-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [N_IN:0]     pattern_cnt
);

    localparam logic [1:0]    c_IDLE    = 2'd0;
    localparam logic [1:0]    c_RUN     = 2'd1;
    localparam logic [1:0]    c_DRAIN   = 2'd2;
    localparam logic [1:0]    c_DONE    = 2'd3;
    localparam logic [N_IN:0] c_LAST    = {1'b0, {N_IN{1'b1}}};
    localparam logic [N_IN:0] c_CNT_ONE = {{N_IN{1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [N_IN:0]    r_cnt;
    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_sig_next;
    logic [SIG_W-1:0] w_resp;
    logic             w_launch;
    logic             w_valid;
    logic             w_drain_last;

    // A start is honoured only when no run is in flight.
    assign w_launch = ((r_state == c_IDLE) || (r_state == c_DONE)) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (start) begin
                    w_next = c_RUN;
                end
            end
            c_RUN: begin
                if (r_cnt == c_LAST) begin
                    w_next = (LAT > 0) ? c_DRAIN : c_DONE;
                end
            end
            c_DRAIN: begin
                if (w_drain_last) begin
                    w_next = c_DONE;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        dut_in = '0;
        case (r_state)
            c_RUN: begin
                busy   = 1'b1;
                dut_in = r_cnt[N_IN-1:0];
            end
            c_DRAIN: begin
                busy   = 1'b1;
                dut_in = '1;
            end
            c_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
        pass = done && (r_sig == golden_sig);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_launch) begin
            r_cnt <= '0;
        end else if (r_state == c_RUN) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    always_comb begin
        w_resp              = '0;
        w_resp[N_OUT-1:0]   = dut_out;
        w_sig_next          = {r_sig[SIG_W-2:0], 1'b0}
                              ^ (r_sig[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                              ^ w_resp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= '0;
        end else if (w_launch) begin
            r_sig <= '0;
        end else if (w_valid) begin
            r_sig <= w_sig_next;
        end
    end

    // The valid pipe tracks which DUT output cycles carry a real response.
    generate
        if (LAT > 0) begin : g_valid_pipe
            localparam logic [1:0]     c_DRAIN_INIT = 2'(LAT - 1);
            localparam logic [LAT-1:0] c_PIPE_IN    = LAT'(1);

            logic [LAT-1:0] r_vpipe;
            logic [1:0]     r_drain;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vpipe <= '0;
                    r_drain <= 2'd0;
                end else begin
                    if (w_launch) begin
                        r_vpipe <= '0;
                    end else if (r_state == c_RUN) begin
                        r_vpipe <= (r_vpipe << 1) | c_PIPE_IN;
                    end else begin
                        r_vpipe <= r_vpipe << 1;
                    end
                    if ((r_state == c_RUN) && (r_cnt == c_LAST)) begin
                        r_drain <= c_DRAIN_INIT;
                    end else if ((r_state == c_DRAIN) && (r_drain != 2'd0)) begin
                        r_drain <= r_drain - 2'd1;
                    end
                end
            end

            assign w_valid      = r_vpipe[LAT-1];
            assign w_drain_last = (r_drain == 2'd0);
        end else begin : g_no_pipe
            assign w_valid      = (r_state == c_RUN);
            assign w_drain_last = 1'b1;
        end
    endgenerate

    assign signature   = r_sig;
    assign pattern_cnt = r_cnt;

endmodule
`default_nettype wire
